prach_hb2_sched: RTL
====================

# prach_hb2_sched

Input scheduler for the 2:1 half-band decimator stage of the PRACH long-sequence chain. It accepts the channel-interleaved TDM sample stream and splits each channel's consecutive sample pair into two polyphase lanes. Even-phase samples go to `dout_dp1` and odd-phase samples to `dout_dp2`. Completed pairs are emitted as one contiguous channel-ordered burst with sync and channel tags. It sits directly upstream of the half-band channel filter and owns frame-phase tracking and channel-order checking for that stage.

## Interface
- `NUM_CHANNEL`, 32: channels per TDM frame; must be a power of 2, ≤ 256.
- `DATA_WIDTH`, 16: sample width.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din_dq`  in  DATA_WIDTH  input sample.
- `din_dv`  in  1  input beat valid.
- `din_chn`  in  8  input channel index.
- `sync_in`  in  1  frame start; only meaningful with `din_dv=1`, `din_chn=0`.
- `dout_dp1`  out  DATA_WIDTH  even-phase sample.
- `dout_dp2`  out  DATA_WIDTH  odd-phase sample.
- `dout_dv`  out  1  output beat valid.
- `dout_chn`  out  8  output channel index.
- `sync_out`  out  1  first beat of the first burst after a sync.
- `err_chn`  out  1  one-cycle pulse on channel-order or sync error.
- `err_sticky`  out  1  latched error; cleared by a valid sync.

## Operation
- FSM states: WAIT_SYNC (reset state), PH0, PH1. An expected-channel counter `exp_chn` counts 0..NUM_CHANNEL-1 on each accepted beat.
- **Valid sync.** `sync_in & din_dv & din_chn==0` in any state:
  - clears `err_sticky`;
  - sets `exp_chn=1`;
  - enters PH0;
  - writes that beat as the even sample of channel 0;
  - marks the next burst for `sync_out`.
- **Malformed sync.** `sync_in` with `din_dv=0` or `din_chn!=0`:
  - pulses `err_chn`;
  - sets `err_sticky`;
  - enters WAIT_SYNC.
- **In WAIT_SYNC.** Non-sync beats are dropped with no error.
- **In PH0/PH1.** A beat with `din_chn != exp_chn` pulses `err_chn`, sets `err_sticky`, discards the partial pair frame and enters WAIT_SYNC.
- **Storage.** Two banks of NUM_CHANNEL × 2·DATA_WIDTH (ping-pong).
  - PH0 writes the low half (dp1) of write bank `wb` at address `din_chn`.
  - PH1 writes the high half (dp2).
- **Phase transitions.**
  - PH0 beat with `chn=NUM_CHANNEL-1` → PH1.
  - PH1 beat with `chn=NUM_CHANNEL-1` → PH0, toggles `wb`, and launches readout of the just-completed bank.
- **Readout.** A counter emits channels 0..NUM_CHANNEL-1 on consecutive cycles, independent of input activity. An FSM abort (error or new sync) does not stop a burst already launched. A new launch cannot occur before the current burst ends (≥ 2·NUM_CHANNEL input beats separate launches).
- **Output fields.** `sync_out` is asserted only with `dout_chn=0` of the first burst following a valid sync. `dout_dp1`/`dout_dp2`/`dout_chn` are zero when `dout_dv=0`.
- **Arithmetic.** None; samples pass bit-exact.

## Timing
- All outputs are registered.
- Reset values: every output is 0; FSM = WAIT_SYNC; `wb` = 0; readout idle.
- Last PH1 beat accepted at cycle T → `dout_dv=1` for cycles T+2 .. T+1+NUM_CHANNEL, with `dout_chn` = 0..NUM_CHANNEL-1.
- The bank write of the beat at T completes at T+1, before its read (same-bank read of channel NUM_CHANNEL-1 at T+1+NUM_CHANNEL−1).
- `err_chn` is asserted on cycle T+1 for an offending beat at T.
- Simultaneous error and last-PH1 beat: the error wins; no readout launch, no `wb` toggle.
- Reset asserted mid-burst: `dout_dv` drops asynchronously; the burst is not resumed.

## Structure
- `prach_pkg` holds the constants `PrachNumChannel=32`, `PrachDataWidth=16`, and the state enum typedef `hb2_sched_state_e`.
- Sub-module `prach_sdpram`: simple dual-port RAM with 1-cycle registered read, depth 2·NUM_CHANNEL, width 2·DATA_WIDTH, byte-lane write enable per half. Bank select is the address MSB.

## Test plan
- **Nominal pair.** Sync plus two full frames with `din_dq = chn` (PH0) and `din_dq = 0x100+chn` (PH1), back-to-back.
  - Burst at T+2: `dout_dp1=k`, `dout_dp2=0x100+k`, `dout_chn=k` for k = 0..31.
  - `sync_out` only on k=0.
- **Gapped input.** Random `din_dv` gaps (50%).
  - Same data as nominal.
  - Burst contiguous 32 cycles.
  - `sync_out` on the first burst only; the second burst has `sync_out=0`.
- **Channel skip.** `din_chn` jumps 5→7 in PH1.
  - `err_chn` pulse, `err_sticky=1`.
  - No burst.
  - Subsequent beats ignored until sync; a valid sync clears `err_sticky`.
- **Bad sync.** `sync_in=1` with `din_chn=3`.
  - Error pulse; FSM in WAIT_SYNC.
  - The next valid sync produces a correct burst.
- **Sync mid-burst.** Valid sync during cycle 10 of a burst.
  - Burst completes all 32 beats unchanged.
  - The next burst carries `sync_out`.
- **Async reset mid-burst.** Assert `rst_n=0` at beat 12.
  - All outputs 0 immediately.
  - After release, no output until sync plus 64 beats.

Source files
------------

// File: rtl/prach_pkg.sv
// rtl/prach_pkg.sv - shared constants and state type for the PRACH half-band stage
package prach_pkg;

    localparam int PrachNumChannel = 32;
    localparam int PrachDataWidth  = 16;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        PH0       = 2'd1,
        PH1       = 2'd2
    } hb2_sched_state_e;

endpackage

// File: rtl/prach_sdpram.sv
// rtl/prach_sdpram.sv - simple dual-port RAM, per-half write enable, registered read
module prach_sdpram #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int HALF_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                we,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [2*HALF_WIDTH-1:0]   wdata,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic [2*HALF_WIDTH-1:0]   rdata
);

    logic [2*HALF_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) begin
            mem[waddr][HALF_WIDTH-1:0] <= wdata[HALF_WIDTH-1:0];
        end
        if (we[1]) begin
            mem[waddr][2*HALF_WIDTH-1:HALF_WIDTH] <= wdata[2*HALF_WIDTH-1:HALF_WIDTH];
        end
    end

    // Read register doubles as the output register, so it returns zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/prach_hb2_sched.sv
// rtl/prach_hb2_sched.sv - splits TDM channel pairs into two polyphase lanes, emits bursts
module prach_hb2_sched
    import prach_pkg::*;
#(
    parameter int NUM_CHANNEL = PrachNumChannel,
    parameter int DATA_WIDTH  = PrachDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_dq,
    input  logic                  din_dv,
    input  logic [7:0]            din_chn,
    input  logic                  sync_in,
    output logic [DATA_WIDTH-1:0] dout_dp1,
    output logic [DATA_WIDTH-1:0] dout_dp2,
    output logic                  dout_dv,
    output logic [7:0]            dout_chn,
    output logic                  sync_out,
    output logic                  err_chn,
    output logic                  err_sticky
);

    localparam int CW = $clog2(NUM_CHANNEL);
    localparam logic [CW-1:0] LAST = CW'(NUM_CHANNEL - 1);

    hb2_sched_state_e state, state_nx;
    logic [CW-1:0]    exp_chn, exp_nx;
    logic             wb, wb_nx;
    logic             sync_pend, pend_nx;
    logic             sticky_nx;
    logic             err;
    logic             launch;
    logic [1:0]       ram_we;
    logic [CW-1:0]    ram_wchn;

    logic             valid_sync;
    logic             chn_ok;

    logic             rd_busy;
    logic [CW-1:0]    rd_cnt;
    logic             rd_bank;
    logic             rd_sync;
    logic [2*DATA_WIDTH-1:0] ram_rdata;

    assign valid_sync = sync_in & din_dv & (din_chn == 8'd0);
    assign chn_ok     = (din_chn == 8'(exp_chn));

    always_comb begin
        state_nx  = state;
        exp_nx    = exp_chn;
        wb_nx     = wb;
        pend_nx   = sync_pend;
        sticky_nx = err_sticky;
        err       = 1'b0;
        launch    = 1'b0;
        ram_we    = 2'b00;
        ram_wchn  = exp_chn;
        if (valid_sync) begin
            state_nx  = PH0;
            exp_nx    = CW'(1);
            ram_we    = 2'b01;
            ram_wchn  = '0;
            sticky_nx = 1'b0;
            pend_nx   = 1'b1;
        end else if (sync_in) begin
            err      = 1'b1;
            state_nx = WAIT_SYNC;
        end else if (din_dv) begin
            case (state)
                PH0: begin
                    if (chn_ok) begin
                        ram_we = 2'b01;
                        exp_nx = exp_chn + 1'b1;
                        if (exp_chn == LAST) begin
                            state_nx = PH1;
                        end
                    end else begin
                        err      = 1'b1;
                        state_nx = WAIT_SYNC;
                    end
                end
                PH1: begin
                    if (chn_ok) begin
                        ram_we = 2'b10;
                        exp_nx = exp_chn + 1'b1;
                        if (exp_chn == LAST) begin
                            state_nx = PH0;
                            wb_nx    = ~wb;
                            launch   = 1'b1;
                            pend_nx  = 1'b0;
                        end
                    end else begin
                        err      = 1'b1;
                        state_nx = WAIT_SYNC;
                    end
                end
                default: ;
            endcase
        end
        if (err) begin
            sticky_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_SYNC;
            exp_chn    <= '0;
            wb         <= 1'b0;
            sync_pend  <= 1'b0;
            err_chn    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nx;
            exp_chn    <= exp_nx;
            wb         <= wb_nx;
            sync_pend  <= pend_nx;
            err_chn    <= err;
            err_sticky <= sticky_nx;
        end
    end

    // Readout runs to completion regardless of what the input FSM does next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy <= 1'b0;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            rd_sync <= 1'b0;
        end else if (launch) begin
            rd_busy <= 1'b1;
            rd_cnt  <= '0;
            rd_bank <= wb;
            rd_sync <= sync_pend;
        end else if (rd_busy) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == LAST) begin
                rd_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dv  <= 1'b0;
            dout_chn <= 8'd0;
            sync_out <= 1'b0;
        end else begin
            dout_dv  <= rd_busy;
            dout_chn <= rd_busy ? 8'(rd_cnt) : 8'd0;
            sync_out <= rd_busy & rd_sync & (rd_cnt == '0);
        end
    end

    prach_sdpram #(
        .DEPTH      (2 * NUM_CHANNEL),
        .ADDR_WIDTH (CW + 1),
        .HALF_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr ({wb, ram_wchn}),
        .wdata ({din_dq, din_dq}),
        .re    (rd_busy),
        .raddr ({rd_bank, rd_cnt}),
        .rdata (ram_rdata)
    );

    assign dout_dp1 = ram_rdata[DATA_WIDTH-1:0];
    assign dout_dp2 = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule
